// File: rtl/port_tx_queue.sv
// port_tx_queue: byte FIFO that paces Port tr_start/din against tr_free.
// Optional shadow-FIFO loopback checker enabled by defining LOOPBACK_CHECK_EN.
module port_tx_queue #(
  parameter int DATA_LEN    = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_LEN-1:0]   wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  tr_free,
  output logic                  tr_start,
  output logic [DATA_LEN-1:0]   din,
  output logic                  busy,
  output logic                  ack_err,
  input  logic                  rec_complete,
  input  logic [DATA_LEN-1:0]   dout,
  output logic                  lb_err
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;
  state_t state_q;
  logic [DATA_LEN-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_q, rp_q;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic [CW-1:0] cnt_q;
  logic [DATA_LEN-1:0] din_q;
  logic tr_start_q, busy_q, ack_err_q, push, pop;
  assign full = level_q == (DEPTH_LOG2+1)'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign tr_start = tr_start_q;
  assign din = din_q;
  assign busy = busy_q;
  assign ack_err = ack_err_q;
  assign push = wr_en && !full;
  assign pop = state_q == LOAD;
  assign level_d = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      level_q <= level_d;
    end
  // tr_start is raised on entry to START so it is high for exactly that state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      din_q <= '0;
      tr_start_q <= 1'b0;
      busy_q <= 1'b0;
      ack_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      tr_start_q <= 1'b0;
      case (state_q)
        IDLE: if (!empty && tr_free) begin
          state_q <= LOAD;
          busy_q <= 1'b1;
        end
        LOAD: begin
          din_q <= mem_q[rp_q];
          tr_start_q <= 1'b1;
          state_q <= START;
        end
        START: begin
          cnt_q <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: if (!tr_free) state_q <= WAIT_DONE;
          else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            ack_err_q <= 1'b1;
            tr_start_q <= 1'b1;
            state_q <= START;
          end else cnt_q <= cnt_q + 1'b1;
        WAIT_DONE: if (tr_free) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
`ifdef LOOPBACK_CHECK_EN
  logic [DATA_LEN-1:0] sh_q [DEPTH];
  logic [DEPTH_LOG2-1:0] swp_q, srp_q;
  logic [DEPTH_LOG2:0] slevel_q;
  logic lb_err_q, spush, spop;
  assign spush = pop && slevel_q != (DEPTH_LOG2+1)'(DEPTH);
  assign spop = rec_complete && slevel_q != '0;
  assign lb_err = lb_err_q;
  always_ff @(posedge clk)
    if (spush) sh_q[swp_q] <= mem_q[rp_q];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      swp_q <= '0;
      srp_q <= '0;
      slevel_q <= '0;
      lb_err_q <= 1'b0;
    end else begin
      if (spush) swp_q <= swp_q + 1'b1;
      if (spop) srp_q <= srp_q + 1'b1;
      slevel_q <= slevel_q + (DEPTH_LOG2+1)'(spush) - (DEPTH_LOG2+1)'(spop);
      if (rec_complete && (slevel_q == '0 || dout != sh_q[srp_q])) lb_err_q <= 1'b1;
    end
`else
  logic unused_lb;
  assign unused_lb = ^{rec_complete, dout};
  assign lb_err = 1'b0;
`endif
endmodule

// File: tb/tb_port_tx_queue.sv
// tb_port_tx_queue: table-driven fill vectors plus scoreboarded frame sequences.
module tb_port_tx_queue;
  logic clk, reset, wr_en, tr_free, rec_complete;
  logic [7:0] wr_data, din, dout;
  logic full, empty, tr_start, busy, ack_err, lb_err;
  logic [4:0] level;
  int checks = 0, errors = 0;
  logic [7:0] sb [$];
  typedef struct {
    logic [7:0] data;
    logic [4:0] lvl;
    logic f;
    logic e;
  } vec_t;
  vec_t v [17];

  port_tx_queue dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .tr_free(tr_free),
    .tr_start(tr_start), .din(din), .busy(busy), .ack_err(ack_err),
    .rec_complete(rec_complete), .dout(dout), .lb_err(lb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    if (sb.size() < 16) sb.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_start();
    bit ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (tr_start) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("start_timeout", 32'(tr_start), 1);
  endtask

  task automatic serve();
    logic [7:0] e;
    wait_start();
    e = sb.size() != 0 ? sb.pop_front() : 8'h00;
    chk("din", din, e);
    tick();
    chk("start_pulse", tr_start, 0);
    tr_free = 1'b0;
    tick();
    tick();
    chk("din_hold", din, e);
    tr_free = 1'b1;
    tick();
    chk("busy_idle", busy, 0);
  endtask

  task automatic rec(input logic [7:0] b);
    dout = b;
    rec_complete = 1'b1;
    tick();
    rec_complete = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 17; i++)
      v[i] = '{8'(i), (i < 16) ? 5'(i + 1) : 5'd16, i >= 15, 1'b0};
    reset = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    tr_free = 1'b1;
    rec_complete = 1'b0;
    dout = 8'h00;
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_start", tr_start, 0);
    chk("rst_din", din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ackerr", ack_err, 0);
    chk("rst_lberr", lb_err, 0);
    reset = 1'b1;
    tick();
    push(8'hA5);
    chk("lat1_empty", empty, 0);
    chk("lat1_start", tr_start, 0);
    tick();
    chk("lat2_busy", busy, 1);
    chk("lat2_start", tr_start, 0);
    tick();
    chk("lat3_start", tr_start, 1);
    serve();
    chk("lat_empty", empty, 1);
    tr_free = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push(v[i].data);
      chk("fill_level", level, v[i].lvl);
      chk("fill_full", full, v[i].f);
      chk("fill_empty", empty, v[i].e);
    end
    chk("stall_busy", busy, 0);
    chk("stall_start", tr_start, 0);
    tr_free = 1'b1;
    repeat (16) serve();
    chk("drain_empty", empty, 1);
    chk("drain_level", level, 0);
    chk("drain_sb", sb.size(), 0);
    push(8'h5A);
    wait_start();
    chk("to_din", din, 8'h5A);
    repeat (15) tick();
    chk("to_noerr", ack_err, 0);
    chk("to_nostart", tr_start, 0);
    tick();
    chk("to_err", ack_err, 1);
    chk("to_restart", tr_start, 1);
    chk("to_same_din", din, 8'h5A);
    serve();
    chk("to_sticky", ack_err, 1);
    tr_free = 1'b0;
    repeat (5) push(8'($urandom));
    chk("pp_level5", level, 5);
    tr_free = 1'b1;
    tick();
    chk("pp_load", busy, 1);
    push(8'($urandom));
    chk("pp_level", level, 5);
    repeat (6) serve();
    chk("pp_empty", empty, 1);
    for (int r = 0; r < 2; r++) begin
      tr_free = 1'b0;
      repeat (10) push(8'($urandom));
      tr_free = 1'b1;
      repeat (10) serve();
    end
    chk("wrap_empty", empty, 1);
    chk("wrap_sb", sb.size(), 0);
    tr_free = 1'b0;
    repeat (5) push(8'($urandom));
    tr_free = 1'b1;
    wait_start();
    tick();
    tr_free = 1'b0;
    tick();
    chk("mr_level", level, 4);
    chk("mr_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_start", tr_start, 0);
    chk("mr_empty", empty, 1);
    chk("mr_busy0", busy, 0);
    chk("mr_level0", level, 0);
    chk("mr_ackerr", ack_err, 0);
    sb.delete();
    tick();
    reset = 1'b1;
    tr_free = 1'b1;
    tick();
    push(8'h3C);
    serve();
`ifdef LOOPBACK_CHECK_EN
    rec(8'h3C);
    chk("lb_match", lb_err, 0);
    push(8'h3C);
    serve();
    rec(8'h3D);
    chk("lb_mismatch", lb_err, 1);
`else
    rec(8'h3D);
    chk("lb_off", lb_err, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
